cpu_axi_bridge: RTL and testbench
=================================

Name: cpu_axi_bridge

Overview:
- Converts the CPU's two sram-like master ports (instruction fetch, data load/store) into one AXI3 master port.
- Sits directly downstream of the pipeline top level, between the core and the system AXI interconnect.
- Lets instruction and data SRAMs be replaced by a shared AXI memory with variable latency.
- One outstanding transaction per sram-like port; in-order responses per port.

Parameters:
- INST_ID, 4'd0, AXI arid used for instruction reads.
- DATA_ID, 4'd1, AXI arid/awid/wid used for data accesses.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- inst_req  in  1  instruction request valid.
- inst_addr  in  32  fetch address (word aligned).
- inst_addr_ok  out  1  request accepted this cycle (inst_req && inst_addr_ok).
- inst_data_ok  out  1  fetch data returned this cycle.
- inst_rdata  out  32  fetched word.
- data_req  in  1  data request valid.
- data_wr  in  1  1 = store, 0 = load.
- data_size  in  2  0 = byte, 1 = half, 2 = word.
- data_wstrb  in  4  store byte enables.
- data_addr  in  32  data address.
- data_wdata  in  32  store data.
- data_addr_ok  out  1  request accepted this cycle.
- data_data_ok  out  1  load data returned or store completed this cycle.
- data_rdata  out  32  load word (unshifted).
- arid  out  4;  araddr  out  32;  arsize  out  3;  arvalid  out  1;  arready  in  1.
- arlen/arburst/arlock/arcache/arprot  out  8/2/2/4/3  constants 0/2'b01/0/0/0.
- rid  in  4;  rdata  in  32;  rresp  in  2;  rlast  in  1;  rvalid  in  1;  rready  out  1.
- awid  out  4;  awaddr  out  32;  awsize  out  3;  awvalid  out  1;  awready  in  1.
- awlen/awburst/awlock/awcache/awprot  out  constants as the AR side.
- wid  out  4;  wdata  out  32;  wstrb  out  4;  wlast  out  1 (const 1);  wvalid  out  1;  wready  in  1.
- bid  in  4;  bresp  in  2;  bvalid  in  1;  bready  out  1.

Behaviour:
- Reset values: all valids 0, all pending flags 0, AR FSM AR_IDLE, W FSM W_IDLE, araddr/awaddr/wdata/wstrb 0.
- rready and bready are constant 1. This is legal because each ID has at most one outstanding transaction.

Per-port pending flags:
- inst_pend is set on inst accept and cleared on rvalid && rid==INST_ID.
- data_pend is set on data accept and cleared on (rvalid && rid==DATA_ID) or bvalid.
- The data port carries at most one outstanding transaction, read or write, so no RAW check is needed.

AR FSM:
- AR_IDLE -> AR_BUSY on accept of any read; arvalid=1 from the next cycle (registered, 1-cycle latency).
- AR_BUSY -> AR_IDLE on arvalid && arready.

Read arbitration, in AR_IDLE only:
- Data read wins over inst read.
- data_addr_ok(read) = AR_IDLE && !data_pend.
- inst_addr_ok = AR_IDLE && !inst_pend && !(data_req && !data_wr && !data_pend).
- inst_addr_ok = 0 in the same cycle a data read is accepted.

W FSM:
- W_IDLE -> W_SEND on data write accept; awvalid=wvalid=1 next cycle.
- In W_SEND, awvalid drops on its own handshake and wvalid drops on its own handshake, independently.
- W_SEND -> W_RESP when both channels have handshaken; if both handshake in the same cycle, go to W_RESP directly.
- W_RESP -> W_IDLE on bvalid.
- data_addr_ok(write) = W_IDLE && !data_pend.

Field mapping:
- arsize/awsize = {1'b0, data_size}; inst reads use size 3'd2.
- araddr/awaddr = the accepted address, unmodified.

Responses:
- data_ok is combinational in the rvalid/bvalid cycle (0-cycle pass-through); inst_rdata/data_rdata = rdata.
- Simultaneous inst and data R beats cannot occur (one R channel). An inst R beat and a data B beat in the same cycle are both reported.
- rresp/bresp are ignored (no exception support yet).

Accept-and-complete in the same cycle:
- A completing transaction does not clear data_pend in time to admit a new request in that cycle.
- addr_ok uses the registered pending flags only, so a new request is accepted one cycle after data_ok.

Reset mid-operation:
- All state is cleared; in-flight AXI transactions are abandoned (the slave is reset by the same signal).

Decomposition:
- Shared package: AXI constant encodings (burst INCR, size codes), ID constants, AR/W state enums.
- Natural sub-module: cpu_axi_bridge_wr, the AW/W/B FSM, instantiated once. Read arbitration stays in the top.

Test Plan:
1. Inst fetch at 0x1C000000, arready=1 at first arvalid, rvalid 3 cycles later with rid=0, rdata=0x02800C0C -> arvalid 1 cycle after accept, araddr=0x1C000000, arsize=2, inst_data_ok=1 with inst_rdata=0x02800C0C, inst_addr_ok re-asserts the next cycle.
2. inst_req and data load (addr 0x1C008004, size 0) in the same idle cycle -> data accepted first (arid=1, arsize=0), inst_addr_ok=0 that cycle, inst accepted once AR returns to AR_IDLE.
3. Store addr 0x1C008000, wstrb 4'b0011, wdata 0xDEADBEEF; awready delayed 2 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid holds 3 cycles, data_data_ok in the bvalid cycle, next data_addr_ok the cycle after.
4. Data load outstanding with a second data_req held -> data_addr_ok=0 until the cycle after data_data_ok.
5. Inst R beat and data B beat arriving in the same cycle -> inst_data_ok=1 and data_data_ok=1 together.
6. reset=1 asserted while in W_SEND with inst_pend=1 -> next cycle all valids 0, both addr_ok=1 once reset deasserts.

Source files
------------

// File: rtl/cpu_axi_bridge_pkg.sv
// Shared encodings for the CPU sram-like to AXI3 bridge.
// AXI constants, default IDs and the AR/W state enums.
package cpu_axi_bridge_pkg;

  localparam logic [3:0] INST_ID_DEF = 4'd0;
  localparam logic [3:0] DATA_ID_DEF = 4'd1;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_WORD  = 3'd2;

  typedef enum logic {
    AR_IDLE,
    AR_BUSY
  } ar_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_SEND,
    W_RESP
  } w_state_e;

  function automatic logic [2:0] axi_size(input logic [1:0] s);
    return {1'b0, s};
  endfunction

endpackage

// File: rtl/cpu_axi_bridge_if.sv
// AXI3 master/slave bundle used between the bridge and the interconnect.
// Single-beat only; burst/len fields are still carried for the interconnect.
interface cpu_axi_bridge_if;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;

  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst,
    output arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst,
    output awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst,
    input  arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst,
    input  awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

endinterface

// File: rtl/cpu_axi_bridge_wr.sv
// AW/W/B sequencer for data-port stores.
// AW and W retire independently; B is awaited once both are done.
module cpu_axi_bridge_wr
  import cpu_axi_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        acc_i,
  input  logic [31:0] addr_i,
  input  logic [1:0]  size_i,
  input  logic [3:0]  wstrb_i,
  input  logic [31:0] wdata_i,
  input  logic        awready_i,
  input  logic        wready_i,
  input  logic        bvalid_i,
  output logic        idle_o,
  output logic        awvalid_o,
  output logic [31:0] awaddr_o,
  output logic [2:0]  awsize_o,
  output logic        wvalid_o,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o
);

  w_state_e    w_q, w_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic [2:0]  awsize_q, awsize_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        aw_hs, w_hs;

  assign aw_hs = awvalid_q & awready_i;
  assign w_hs  = wvalid_q & wready_i;

  always_comb begin
    w_d       = w_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    awaddr_d  = awaddr_q;
    awsize_d  = awsize_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    unique case (w_q)
      W_IDLE: begin
        if (acc_i) begin
          w_d       = W_SEND;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          awaddr_d  = addr_i;
          awsize_d  = axi_size(size_i);
          wdata_d   = wdata_i;
          wstrb_d   = wstrb_i;
        end
      end
      W_SEND: begin
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        // both channels done, possibly in this very cycle
        if ((~awvalid_q | aw_hs) & (~wvalid_q | w_hs))
          w_d = W_RESP;
      end
      W_RESP: begin
        if (bvalid_i) w_d = W_IDLE;
      end
      default: w_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_q       <= W_IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      awaddr_q  <= '0;
      awsize_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      w_q       <= w_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      awaddr_q  <= awaddr_d;
      awsize_q  <= awsize_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
    end
  end

  assign idle_o    = (w_q == W_IDLE);
  assign awvalid_o = awvalid_q;
  assign awaddr_o  = awaddr_q;
  assign awsize_o  = awsize_q;
  assign wvalid_o  = wvalid_q;
  assign wdata_o   = wdata_q;
  assign wstrb_o   = wstrb_q;

endmodule

// File: rtl/cpu_axi_bridge.sv
// Merges the inst-fetch and data sram-like ports onto one AXI3 master.
// One outstanding access per port; data reads beat inst reads for AR.
module cpu_axi_bridge
  import cpu_axi_bridge_pkg::*;
#(
  parameter logic [3:0] INST_ID = INST_ID_DEF,
  parameter logic [3:0] DATA_ID = DATA_ID_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  cpu_axi_bridge_if.master axi
);

  ar_state_e   ar_q, ar_d;
  logic [3:0]  arid_q, arid_d;
  logic [31:0] araddr_q, araddr_d;
  logic [2:0]  arsize_q, arsize_d;
  logic        inst_pend_q, inst_pend_d;
  logic        data_pend_q, data_pend_d;

  logic ar_idle, w_idle;
  logic data_rd_req, data_rd_ok, data_wr_ok;
  logic data_rd_acc, data_wr_acc, inst_acc;
  logic r_inst, r_data;
  logic unused_ok;

  assign ar_idle     = (ar_q == AR_IDLE);
  assign data_rd_req = data_req & ~data_wr;
  assign data_rd_ok  = ar_idle & ~data_pend_q;
  assign data_wr_ok  = w_idle & ~data_pend_q;

  assign data_addr_ok = data_wr ? data_wr_ok : data_rd_ok;
  assign inst_addr_ok = ar_idle & ~inst_pend_q
                      & ~(data_rd_req & ~data_pend_q);

  assign data_rd_acc = data_rd_req & data_rd_ok;
  assign data_wr_acc = data_req & data_wr & data_wr_ok;
  assign inst_acc    = inst_req & inst_addr_ok;

  assign r_inst = axi.rvalid & (axi.rid == INST_ID);
  assign r_data = axi.rvalid & (axi.rid == DATA_ID);

  assign inst_data_ok = r_inst;
  assign data_data_ok = r_data | axi.bvalid;
  assign inst_rdata   = axi.rdata;
  assign data_rdata   = axi.rdata;

  always_comb begin
    ar_d     = ar_q;
    arid_d   = arid_q;
    araddr_d = araddr_q;
    arsize_d = arsize_q;
    unique case (ar_q)
      AR_IDLE: begin
        unique case (1'b1)
          data_rd_acc: begin
            ar_d     = AR_BUSY;
            arid_d   = DATA_ID;
            araddr_d = data_addr;
            arsize_d = axi_size(data_size);
          end
          inst_acc: begin
            ar_d     = AR_BUSY;
            arid_d   = INST_ID;
            araddr_d = inst_addr;
            arsize_d = SIZE_WORD;
          end
          default: ;
        endcase
      end
      AR_BUSY: begin
        if (axi.arready) ar_d = AR_IDLE;
      end
    endcase
  end

  // completion clears pend only next cycle, so no same-cycle re-accept
  assign inst_pend_d = inst_acc | (inst_pend_q & ~r_inst);
  assign data_pend_d = data_rd_acc | data_wr_acc
                     | (data_pend_q & ~(r_data | axi.bvalid));

  always_ff @(posedge clk) begin
    if (reset) begin
      ar_q        <= AR_IDLE;
      arid_q      <= '0;
      araddr_q    <= '0;
      arsize_q    <= '0;
      inst_pend_q <= 1'b0;
      data_pend_q <= 1'b0;
    end else begin
      ar_q        <= ar_d;
      arid_q      <= arid_d;
      araddr_q    <= araddr_d;
      arsize_q    <= arsize_d;
      inst_pend_q <= inst_pend_d;
      data_pend_q <= data_pend_d;
    end
  end

  cpu_axi_bridge_wr u_wr (
    .clk       (clk),
    .reset     (reset),
    .acc_i     (data_wr_acc),
    .addr_i    (data_addr),
    .size_i    (data_size),
    .wstrb_i   (data_wstrb),
    .wdata_i   (data_wdata),
    .awready_i (axi.awready),
    .wready_i  (axi.wready),
    .bvalid_i  (axi.bvalid),
    .idle_o    (w_idle),
    .awvalid_o (axi.awvalid),
    .awaddr_o  (axi.awaddr),
    .awsize_o  (axi.awsize),
    .wvalid_o  (axi.wvalid),
    .wdata_o   (axi.wdata),
    .wstrb_o   (axi.wstrb)
  );

  assign axi.arid    = arid_q;
  assign axi.araddr  = araddr_q;
  assign axi.arsize  = arsize_q;
  assign axi.arvalid = (ar_q == AR_BUSY);
  assign axi.arlen   = 8'd0;
  assign axi.arburst = BURST_INCR;
  assign axi.arlock  = 2'd0;
  assign axi.arcache = 4'd0;
  assign axi.arprot  = 3'd0;
  assign axi.rready  = 1'b1;

  assign axi.awid    = DATA_ID;
  assign axi.awlen   = 8'd0;
  assign axi.awburst = BURST_INCR;
  assign axi.awlock  = 2'd0;
  assign axi.awcache = 4'd0;
  assign axi.awprot  = 3'd0;
  assign axi.wid     = DATA_ID;
  assign axi.wlast   = 1'b1;
  assign axi.bready  = 1'b1;

  // responses are always OKAY-treated; no exception path yet
  assign unused_ok = ^{axi.rresp, axi.rlast, axi.bid, axi.bresp};

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Bench for cpu_axi_bridge: directed scenarios plus a randomized
// run against a word-memory reference and a simple AXI slave.
module tb_cpu_axi_bridge;
  import cpu_axi_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  int          total = 0;
  int          bad = 0;

  cpu_axi_bridge_if axi ();

  cpu_axi_bridge dut (
    .clk          (clk),
    .reset        (reset),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_wstrb   (data_wstrb),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .axi          (axi)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_in();
    inst_req = 0; inst_addr = '0;
    data_req = 0; data_wr = 0; data_size = '0;
    data_wstrb = '0; data_addr = '0; data_wdata = '0;
    axi.arready = 0; axi.rvalid = 0; axi.rid = '0;
    axi.rdata = '0; axi.rresp = '0; axi.rlast = 1;
    axi.awready = 0; axi.wready = 0;
    axi.bvalid = 0; axi.bid = '0; axi.bresp = '0;
  endtask

  task automatic do_reset();
    idle_in();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  function automatic logic [31:0] merge(
    input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  function automatic logic [4:0] midx(input logic [31:0] a);
    return {a[15], a[5:2]};
  endfunction

  task automatic test_reset();
    do_reset();
    smp();
    total++; if ({axi.arvalid, axi.awvalid, axi.wvalid} !== 3'b000) begin bad++; $display("FAIL rst_valids: got %b want 000", {axi.arvalid, axi.awvalid, axi.wvalid}); end
    total++; if ({inst_addr_ok, data_addr_ok} !== 2'b11) begin bad++; $display("FAIL rst_addr_ok: got %b want 11", {inst_addr_ok, data_addr_ok}); end
    total++; if ({axi.araddr, axi.awaddr, axi.wdata, axi.wstrb} !== 100'd0) begin bad++; $display("FAIL rst_regs: got %h %h %h %h want 0", axi.araddr, axi.awaddr, axi.wdata, axi.wstrb); end
    total++; if ({axi.rready, axi.bready, axi.wlast, axi.arburst, axi.awburst, axi.arlen} !== {3'b111, 2'b01, 2'b01, 8'd0}) begin bad++; $display("FAIL rst_consts: got %b", {axi.rready, axi.bready, axi.wlast, axi.arburst, axi.awburst, axi.arlen}); end
    tick();
  endtask

  task automatic test_inst_fetch();
    inst_req = 1; inst_addr = 32'h1C000000; axi.arready = 1;
    smp();
    total++; if (inst_addr_ok !== 1'b1) begin bad++; $display("FAIL if_accept: got %b want 1", inst_addr_ok); end
    tick();
    inst_req = 0;
    smp();
    total++; if ({axi.arvalid, axi.arid, axi.arsize, axi.araddr} !== {1'b1, 4'd0, 3'd2, 32'h1C000000}) begin bad++; $display("FAIL if_ar: got %b %h %h %h want 1 0 2 1c000000", axi.arvalid, axi.arid, axi.arsize, axi.araddr); end
    tick();
    smp();
    total++; if (axi.arvalid !== 1'b0) begin bad++; $display("FAIL if_ar_drop: got %b want 0", axi.arvalid); end
    tick();
    tick();
    axi.rvalid = 1; axi.rid = 4'd0; axi.rdata = 32'h02800C0C;
    smp();
    total++; if ({inst_data_ok, inst_rdata, inst_addr_ok} !== {1'b1, 32'h02800C0C, 1'b0}) begin bad++; $display("FAIL if_data: got %b %h %b want 1 02800c0c 0", inst_data_ok, inst_rdata, inst_addr_ok); end
    tick();
    axi.rvalid = 0; axi.arready = 0;
    smp();
    total++; if (inst_addr_ok !== 1'b1) begin bad++; $display("FAIL if_reok: got %b want 1", inst_addr_ok); end
    tick();
  endtask

  task automatic test_arbitration();
    inst_req = 1; inst_addr = 32'h1C000040;
    data_req = 1; data_wr = 0; data_size = 2'd0; data_addr = 32'h1C008004;
    smp();
    total++; if ({data_addr_ok, inst_addr_ok} !== 2'b10) begin bad++; $display("FAIL arb_prio: got %b want 10", {data_addr_ok, inst_addr_ok}); end
    tick();
    data_req = 0; axi.arready = 1;
    smp();
    total++; if ({axi.arvalid, axi.arid, axi.arsize, axi.araddr, inst_addr_ok} !== {1'b1, 4'd1, 3'd0, 32'h1C008004, 1'b0}) begin bad++; $display("FAIL arb_dar: got %b %h %h %h %b", axi.arvalid, axi.arid, axi.arsize, axi.araddr, inst_addr_ok); end
    tick();
    axi.arready = 0;
    smp();
    total++; if (inst_addr_ok !== 1'b1) begin bad++; $display("FAIL arb_inst_late: got %b want 1", inst_addr_ok); end
    tick();
    inst_req = 0; axi.arready = 1;
    smp();
    total++; if ({axi.arvalid, axi.arid, axi.arsize, axi.araddr} !== {1'b1, 4'd0, 3'd2, 32'h1C000040}) begin bad++; $display("FAIL arb_iar: got %b %h %h %h", axi.arvalid, axi.arid, axi.arsize, axi.araddr); end
    tick();
    axi.arready = 0; axi.rvalid = 1; axi.rid = 4'd1; axi.rdata = 32'h11223344;
    smp();
    total++; if ({data_data_ok, inst_data_ok, data_rdata} !== {2'b10, 32'h11223344}) begin bad++; $display("FAIL arb_dresp: got %b %b %h", data_data_ok, inst_data_ok, data_rdata); end
    tick();
    axi.rid = 4'd0; axi.rdata = 32'h55667788;
    smp();
    total++; if ({inst_data_ok, data_data_ok, inst_rdata} !== {2'b10, 32'h55667788}) begin bad++; $display("FAIL arb_iresp: got %b %b %h", inst_data_ok, data_data_ok, inst_rdata); end
    tick();
    axi.rvalid = 0;
  endtask

  task automatic test_store();
    data_req = 1; data_wr = 1; data_size = 2'd2; data_addr = 32'h1C008000;
    data_wstrb = 4'b0011; data_wdata = 32'hDEADBEEF;
    axi.awready = 0; axi.wready = 1;
    smp();
    total++; if (data_addr_ok !== 1'b1) begin bad++; $display("FAIL st_accept: got %b want 1", data_addr_ok); end
    tick();
    data_req = 0;
    smp();
    total++; if ({axi.awvalid, axi.wvalid, axi.awid, axi.wid, axi.awsize, axi.awaddr, axi.wdata, axi.wstrb} !== {2'b11, 4'd1, 4'd1, 3'd2, 32'h1C008000, 32'hDEADBEEF, 4'b0011}) begin bad++; $display("FAIL st_aw_w: got %b%b %h %h %h %h %h %h", axi.awvalid, axi.wvalid, axi.awid, axi.wid, axi.awsize, axi.awaddr, axi.wdata, axi.wstrb); end
    tick();
    smp();
    total++; if ({axi.awvalid, axi.wvalid} !== 2'b10) begin bad++; $display("FAIL st_w_drop: got %b want 10", {axi.awvalid, axi.wvalid}); end
    tick();
    axi.awready = 1;
    smp();
    total++; if ({axi.awvalid, axi.wvalid} !== 2'b10) begin bad++; $display("FAIL st_aw_hold: got %b want 10", {axi.awvalid, axi.wvalid}); end
    tick();
    axi.awready = 0;
    smp();
    total++; if ({axi.awvalid, axi.wvalid, data_addr_ok} !== 3'b000) begin bad++; $display("FAIL st_resp_wait: got %b want 000", {axi.awvalid, axi.wvalid, data_addr_ok}); end
    tick();
    axi.bvalid = 1; axi.bid = 4'd1;
    smp();
    total++; if ({data_data_ok, data_addr_ok} !== 2'b10) begin bad++; $display("FAIL st_bresp: got %b want 10", {data_data_ok, data_addr_ok}); end
    tick();
    axi.bvalid = 0;
    smp();
    total++; if (data_addr_ok !== 1'b1) begin bad++; $display("FAIL st_reok: got %b want 1", data_addr_ok); end
    tick();
  endtask

  task automatic test_data_block();
    data_req = 1; data_wr = 0; data_size = 2'd2; data_addr = 32'h1C008010;
    axi.arready = 1;
    smp();
    total++; if (data_addr_ok !== 1'b1) begin bad++; $display("FAIL blk_accept: got %b want 1", data_addr_ok); end
    tick();
    data_addr = 32'h1C008014;
    for (int k = 0; k < 3; k++) begin
      smp();
      total++; if (data_addr_ok !== 1'b0) begin bad++; $display("FAIL blk_hold%0d: got %b want 0", k, data_addr_ok); end
      tick();
    end
    axi.rvalid = 1; axi.rid = 4'd1; axi.rdata = 32'hA5A55A5A;
    smp();
    total++; if ({data_data_ok, data_addr_ok, data_rdata} !== {2'b10, 32'hA5A55A5A}) begin bad++; $display("FAIL blk_done: got %b %b %h", data_data_ok, data_addr_ok, data_rdata); end
    tick();
    axi.rvalid = 0;
    smp();
    total++; if (data_addr_ok !== 1'b1) begin bad++; $display("FAIL blk_reok: got %b want 1", data_addr_ok); end
    tick();
    data_req = 0;
    tick();
    axi.rvalid = 1; axi.rid = 4'd1; axi.rdata = 32'h0;
    smp();
    total++; if (data_data_ok !== 1'b1) begin bad++; $display("FAIL blk_second: got %b want 1", data_data_ok); end
    tick();
    axi.rvalid = 0; axi.arready = 0;
  endtask

  task automatic test_same_cycle();
    inst_req = 1; inst_addr = 32'h1C000080;
    data_req = 1; data_wr = 1; data_size = 2'd2; data_addr = 32'h1C008008;
    data_wstrb = 4'hF; data_wdata = 32'h0BADF00D;
    axi.arready = 1; axi.awready = 1; axi.wready = 1;
    smp();
    total++; if ({inst_addr_ok, data_addr_ok} !== 2'b11) begin bad++; $display("FAIL sc_accept: got %b want 11", {inst_addr_ok, data_addr_ok}); end
    tick();
    inst_req = 0; data_req = 0;
    smp();
    total++; if ({axi.arvalid, axi.awvalid, axi.wvalid} !== 3'b111) begin bad++; $display("FAIL sc_valids: got %b want 111", {axi.arvalid, axi.awvalid, axi.wvalid}); end
    tick();
    axi.arready = 0; axi.awready = 0; axi.wready = 0;
    axi.rvalid = 1; axi.rid = 4'd0; axi.rdata = 32'hCAFEBABE;
    axi.bvalid = 1; axi.bid = 4'd1;
    smp();
    total++; if ({inst_data_ok, data_data_ok, inst_rdata} !== {2'b11, 32'hCAFEBABE}) begin bad++; $display("FAIL sc_both_ok: got %b %b %h", inst_data_ok, data_data_ok, inst_rdata); end
    tick();
    axi.rvalid = 0; axi.bvalid = 0;
  endtask

  task automatic test_reset_mid();
    inst_req = 1; inst_addr = 32'h1C000004;
    data_req = 1; data_wr = 1; data_addr = 32'h1C00800C;
    axi.arready = 1;
    smp();
    total++; if ({inst_addr_ok, data_addr_ok} !== 2'b11) begin bad++; $display("FAIL rm_accept: got %b want 11", {inst_addr_ok, data_addr_ok}); end
    tick();
    inst_req = 0; data_req = 0;
    tick();
    smp();
    total++; if ({axi.awvalid, axi.wvalid, inst_addr_ok} !== 3'b110) begin bad++; $display("FAIL rm_wsend: got %b want 110", {axi.awvalid, axi.wvalid, inst_addr_ok}); end
    tick();
    reset = 1;
    tick();
    smp();
    total++; if ({axi.arvalid, axi.awvalid, axi.wvalid} !== 3'b000) begin bad++; $display("FAIL rm_valids: got %b want 000", {axi.arvalid, axi.awvalid, axi.wvalid}); end
    tick();
    reset = 0;
    smp();
    total++; if ({inst_addr_ok, data_addr_ok} !== 2'b11) begin bad++; $display("FAIL rm_addr_ok_wr: got %b want 11", {inst_addr_ok, data_addr_ok}); end
    tick();
    data_wr = 0; axi.arready = 0;
    smp();
    total++; if (data_addr_ok !== 1'b1) begin bad++; $display("FAIL rm_addr_ok_rd: got %b want 1", data_addr_ok); end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] smem [32];
    logic [31:0] rmem [32];
    int          rq_lat [$];
    logic [3:0]  rq_id [$];
    logic [4:0]  rq_idx [$];
    bit          aw_got, w_got, b_pend;
    logic [4:0]  w_idx;
    logic [31:0] w_dat, i_exp, d_exp;
    logic [3:0]  w_stb;
    logic [1:0]  d_sz;
    logic [2:0]  exp_sz;
    int          b_lat;
    bit          i_out, d_out, d_is_wr, i_drop, d_drop;
    bit          iok, dok, i_acc, d_acc, issue;
    aw_got = 0; w_got = 0; b_pend = 0; b_lat = 0;
    i_out = 0; d_out = 0; d_is_wr = 0; i_drop = 0; d_drop = 0;
    i_exp = '0; d_exp = '0; d_sz = '0; w_idx = '0; w_dat = '0; w_stb = '0;
    for (int i = 0; i < 32; i++) begin
      smem[i] = $urandom;
      rmem[i] = smem[i];
    end
    do_reset();
    for (int cyc = 0; cyc < 5000; cyc++) begin
      issue = (cyc < 2000);
      if (i_drop) inst_req = 0;
      if (d_drop) data_req = 0;
      i_drop = 0; d_drop = 0;
      if (!inst_req && issue && $urandom_range(2) == 0) begin
        inst_req = 1;
        inst_addr = 32'h1C000000 + 32'($urandom_range(15) << 2);
      end
      if (!data_req && issue && $urandom_range(2) == 0) begin
        data_req = 1;
        data_wr = 1'($urandom_range(1));
        data_size = 2'($urandom_range(2));
        data_wstrb = 4'($urandom_range(15, 1));
        data_addr = 32'h1C008000 + 32'($urandom_range(15) << 2);
        data_wdata = $urandom;
      end
      axi.arready = 1'($urandom_range(1));
      axi.awready = 1'($urandom_range(1));
      axi.wready = 1'($urandom_range(1));
      if (rq_lat.size() > 0 && rq_lat[0] == 0) begin
        axi.rvalid = 1; axi.rid = rq_id[0]; axi.rdata = smem[rq_idx[0]];
      end else begin
        axi.rvalid = 0; axi.rid = 4'($urandom_range(15)); axi.rdata = $urandom;
      end
      axi.bvalid = b_pend && b_lat == 0;
      axi.bid = 4'd1;
      smp();
      iok = inst_data_ok;
      dok = data_data_ok;
      i_acc = inst_req && inst_addr_ok;
      d_acc = data_req && data_addr_ok;
      if (iok) begin
        total++; if (!i_out || inst_rdata !== i_exp) begin bad++; $display("FAIL rnd_inst_data: cyc %0d out=%0b got %h want %h", cyc, i_out, inst_rdata, i_exp); end
      end
      if (dok) begin
        total++; if (!d_out || (!d_is_wr && data_rdata !== d_exp)) begin bad++; $display("FAIL rnd_data_resp: cyc %0d out=%0b wr=%0b got %h want %h", cyc, d_out, d_is_wr, data_rdata, d_exp); end
      end
      if (i_acc) begin
        total++; if (i_out || (data_req && !data_wr && data_addr_ok)) begin bad++; $display("FAIL rnd_inst_accept: cyc %0d got accept want hold (out=%0b)", cyc, i_out); end
      end
      if (d_acc) begin
        total++; if (d_out) begin bad++; $display("FAIL rnd_data_accept: cyc %0d got accept want hold", cyc); end
      end
      if (iok) i_out = 0;
      if (dok) d_out = 0;
      if (i_acc) begin
        i_out = 1; i_exp = rmem[midx(inst_addr)]; i_drop = 1;
      end
      if (d_acc) begin
        d_out = 1; d_is_wr = data_wr; d_sz = data_size; d_drop = 1;
        if (data_wr)
          rmem[midx(data_addr)] = merge(rmem[midx(data_addr)], data_wdata, data_wstrb);
        else
          d_exp = rmem[midx(data_addr)];
      end
      if (axi.arvalid && axi.arready) begin
        exp_sz = (axi.arid == 4'd1) ? {1'b0, d_sz} : 3'd2;
        total++; if (axi.arsize !== exp_sz || axi.arid > 4'd1) begin bad++; $display("FAIL rnd_ar: cyc %0d got id %h size %h want size %h", cyc, axi.arid, axi.arsize, exp_sz); end
        rq_lat.push_back(int'($urandom_range(3)));
        rq_id.push_back(axi.arid);
        rq_idx.push_back(midx(axi.araddr));
      end
      if (axi.rvalid) begin
        void'(rq_lat.pop_front());
        void'(rq_id.pop_front());
        void'(rq_idx.pop_front());
      end else if (rq_lat.size() > 0 && rq_lat[0] > 0) begin
        rq_lat[0] = rq_lat[0] - 1;
      end
      if (axi.awvalid && axi.awready) begin
        aw_got = 1; w_idx = midx(axi.awaddr);
      end
      if (axi.wvalid && axi.wready) begin
        w_got = 1; w_dat = axi.wdata; w_stb = axi.wstrb;
      end
      if (axi.bvalid) b_pend = 0;
      else if (b_pend && b_lat > 0) b_lat--;
      if (aw_got && w_got) begin
        smem[w_idx] = merge(smem[w_idx], w_dat, w_stb);
        aw_got = 0; w_got = 0; b_pend = 1;
        b_lat = int'($urandom_range(3));
      end
      if (!issue && !i_out && !d_out && !inst_req && !data_req) break;
      tick();
    end
    total++; if (i_out || d_out || inst_req || data_req) begin bad++; $display("FAIL rnd_drain: got outstanding i=%0b d=%0b want none", i_out, d_out); end
    tick();
    idle_in();
  endtask

  initial begin
    reset = 1;
    idle_in();
    test_reset();
    test_inst_fetch();
    test_arbitration();
    test_store();
    test_data_block();
    test_same_cycle();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
